rope_controller: RTL
====================

# rope_controller

Sequencer for the player's harpoon rope in the bubble-trouble display pipeline. It turns a fire-button press into a rope that grows upward one step per video frame from the floor. The rope ends when it reaches the ceiling or touches a ball, then a cooldown blocks the next shot. Its registered outputs drive the position and size inputs of a rectangle-drawing object, and it reports shot completion to game logic.

## Interface

Parameters:
- CEILING_Y, 32: topmost Y the rope may reach.
- FLOOR_Y, 440: Y of the rope's base; the rope grows upward from here.
- GROW_STEP, 8: pixels added per frame; range 1..64.
- PLAYER_OFFSET_X, 12: added to playerX to centre the rope on the player.
- COOLDOWN_FRAMES, 4: frames of lockout after a shot ends; range 1..255.

Ports:
- clk, in, 1: system clock (pixel clock domain).
- reset, in, 1: synchronous reset, active-high.
- startOfFrame, in, 1: one-cycle pulse once per frame.
- fireButton, in, 1: level signal from the debounced key.
- playerX, in, 11: player top-left X.
- ropeHitBall, in, 1: collision pulse, any cycle, any width.
- topLeftX, out, 11: rope rectangle left X.
- topLeftY, out, 11: rope rectangle top Y.
- ropeHeight, out, 11: FLOOR_Y − topLeftY.
- ropeActive, out, 1: rope is drawn and collidable.
- ropeDone, out, 1: one-cycle pulse when a shot ends.
- doneByHit, out, 1: qualifies ropeDone; 1 = ball hit, 0 = ceiling. Held until the next ropeDone.

## Operation

- Fire edge:
  - fireEdge = fireButton & ~fireButton_d, registered one cycle.
  - A held button produces one edge only.
- States: IDLE, PENDING, EXTEND, COOLDOWN.
- IDLE:
  - fireEdge → PENDING.
- PENDING:
  - On startOfFrame → EXTEND.
  - topLeftX ← playerX + PLAYER_OFFSET_X, sampled that cycle, 11-bit wrap.
  - topLeftY ← FLOOR_Y − GROW_STEP.
  - hitLatch cleared.
- EXTEND:
  - ropeHitBall sets hitLatch in any cycle.
  - On each startOfFrame, apply the first matching rule:
    1. hitLatch or ropeHitBall set → COOLDOWN, ropeDone=1, doneByHit=1.
    2. topLeftY == CEILING_Y → COOLDOWN, ropeDone=1, doneByHit=0.
    3. Otherwise topLeftY ← max(topLeftY − GROW_STEP, CEILING_Y). Compute in 12-bit signed to avoid underflow.
  - topLeftX is frozen for the whole shot.
- COOLDOWN:
  - Entry loads cnt = COOLDOWN_FRAMES.
  - Each startOfFrame decrements cnt.
  - When cnt reaches 0 on a startOfFrame → IDLE.
- fireEdge seen outside IDLE is discarded, not queued.
- ropeActive = (state == EXTEND).
- ropeHeight is registered together with topLeftY.
- When not in EXTEND:
  - topLeftY = FLOOR_Y, ropeHeight = 0.
  - topLeftX holds its last value.

## Timing

- All outputs are registered. Changes caused by startOfFrame appear the cycle after the pulse.
- Reset values (reset high at a clk edge): state=IDLE, topLeftX=0, topLeftY=FLOOR_Y, ropeHeight=0, ropeActive=0, ropeDone=0, doneByHit=0, cnt=0, hitLatch=0, fireButton_d=0.
- Reset mid-shot aborts immediately, with no ropeDone pulse.
- Fire-to-visible latency:
  - The press cycle produces fireEdge one cycle later, which moves the FSM to PENDING.
  - The first startOfFrame after PENDING is entered launches the rope.
  - A fire edge in the same cycle as startOfFrame launches on the following frame.
- ropeHitBall and startOfFrame in the same cycle: the hit wins; no growth occurs that frame.
- Ceiling is reached with topLeftY==CEILING_Y. The rope stays at full height for exactly one frame before ropeDone.
- Lockout: from ropeDone to IDLE is COOLDOWN_FRAMES startOfFrame pulses.

## Test plan

- Launch: playerX=100, fire press, then startOfFrame → topLeftX=112, topLeftY=432, ropeHeight=8, ropeActive=1.
- Ceiling: let the rope grow. After 51 frames topLeftY=32, ropeHeight=408. Frame 52 → ropeDone pulse, doneByHit=0, ropeActive=0. IDLE follows after 4 more frames.
- Clamp: GROW_STEP=7 → the final step clamps topLeftY to 32, never below, with no wrap.
- Hit: a one-cycle ropeHitBall mid-frame at frame 10 → on the next startOfFrame, ropeDone=1, doneByHit=1, topLeftY=440.
  - Repeat with the hit coincident with startOfFrame: same result.
- Fire held or re-pressed:
  - Button held 200 frames → exactly one shot.
  - A press during EXTEND or COOLDOWN is ignored.
  - Release and re-press after IDLE → a new shot with the updated playerX.
- Reset: assert reset during EXTEND at frame 5 → next cycle all outputs are at reset values, with no ropeDone pulse.

Source files
------------

// File: rtl/rope_controller.sv
// rope_controller: turns a fire press into a rope growing one step per frame, ends on ceiling or ball hit, then cools down
`timescale 1ns/1ps
module rope_controller #(
    parameter int CEILING_Y       = 32,
    parameter int FLOOR_Y         = 440,
    parameter int GROW_STEP       = 8,
    parameter int PLAYER_OFFSET_X = 12,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        fireButton,
    input  logic [10:0] playerX,
    input  logic        ropeHitBall,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [10:0] ropeHeight,
    output logic        ropeActive,
    output logic        ropeDone,
    output logic        doneByHit
);
    typedef enum logic [1:0] {IDLE, PENDING, EXTEND, COOLDOWN} state_t;
    localparam logic [10:0] CEIL  = 11'(CEILING_Y);
    localparam logic [10:0] FLOOR = 11'(FLOOR_Y);
    localparam logic [10:0] STEP  = 11'(GROW_STEP);
    localparam logic [10:0] OFFS  = 11'(PLAYER_OFFSET_X);
    localparam logic [7:0]  CD    = 8'(COOLDOWN_FRAMES);

    state_t             state, state_n;
    logic               fire_d, fire_edge, hit_latch, hit_latch_n, hit_now;
    logic               done_n, by_hit_n;
    logic [7:0]         cnt, cnt_n;
    logic [10:0]        x_n, y_n, h_n, y_grow;
    logic signed [11:0] y_sub;

    // one step up from the current top, clamped at the ceiling without wrapping
    assign y_sub   = $signed({1'b0, topLeftY}) - $signed({1'b0, STEP});
    assign y_grow  = (y_sub < $signed({1'b0, CEIL})) ? CEIL : y_sub[10:0];
    assign hit_now = hit_latch | ropeHitBall;

    // next state and next register values for the shot sequence
    always_comb begin
        state_n     = state;
        x_n         = topLeftX;
        y_n         = topLeftY;
        h_n         = ropeHeight;
        cnt_n       = cnt;
        hit_latch_n = hit_latch;
        done_n      = 1'b0;
        by_hit_n    = doneByHit;
        case (state)
            IDLE: state_n = fire_edge ? PENDING : IDLE;
            PENDING: if (startOfFrame) begin
                state_n     = EXTEND;
                x_n         = playerX + OFFS;
                y_n         = FLOOR - STEP;
                h_n         = STEP;
                hit_latch_n = 1'b0;
            end
            EXTEND: begin
                hit_latch_n = hit_now;
                if (startOfFrame) begin
                    if (hit_now || topLeftY == CEIL) begin
                        state_n  = COOLDOWN;
                        done_n   = 1'b1;
                        by_hit_n = hit_now;
                        y_n      = FLOOR;
                        h_n      = '0;
                        cnt_n    = CD;
                    end else begin
                        y_n = y_grow;
                        h_n = FLOOR - y_grow;
                    end
                end
            end
            COOLDOWN: if (startOfFrame) begin
                cnt_n   = cnt - 8'd1;
                state_n = (cnt <= 8'd1) ? IDLE : COOLDOWN;
            end
            default: state_n = IDLE;
        endcase
    end

    // registered state, datapath and outputs; fire edge detected with one cycle of delay
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fire_d     <= 1'b0;
            fire_edge  <= 1'b0;
            hit_latch  <= 1'b0;
            cnt        <= '0;
            topLeftX   <= '0;
            topLeftY   <= FLOOR;
            ropeHeight <= '0;
            ropeActive <= 1'b0;
            ropeDone   <= 1'b0;
            doneByHit  <= 1'b0;
        end else begin
            state      <= state_n;
            fire_d     <= fireButton;
            fire_edge  <= fireButton & ~fire_d;
            hit_latch  <= hit_latch_n;
            cnt        <= cnt_n;
            topLeftX   <= x_n;
            topLeftY   <= y_n;
            ropeHeight <= h_n;
            ropeActive <= (state_n == EXTEND);
            ropeDone   <= done_n;
            doneByHit  <= by_hit_n;
        end
    end
endmodule
